// File: rtl/updown_seq_monitor.sv
// Receive-side checker for a triangle count stream 0..MAXV..0: it locks onto
// the direction, verifies every step, counts turnarounds and flags breaks.
module updown_seq_monitor #(
    parameter int WIDTH = 4,
    parameter int MAXV  = 2**WIDTH - 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] count_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             dir_up,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] turn_cnt,
    output logic [WIDTH-1:0] expected
);

    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAXV);
    localparam logic [WIDTH-1:0] ONE_L = WIDTH'(1);
    localparam logic [CNT_W-1:0] SAT_L = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_UP,
        S_DOWN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [WIDTH-1:0] w_prev_inc;
    logic [WIDTH-1:0] w_prev_dec;
    logic [WIDTH-1:0] w_expected;
    logic             w_mismatch;
    logic             w_turn;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_turn_cnt;

    assign w_prev_inc = r_prev + ONE_L;
    assign w_prev_dec = r_prev - ONE_L;

    // Prediction is only meaningful while locked; the endpoint guards fold the
    // turnaround in so a wrapped value is never accepted as a valid step.
    always_comb begin
        w_expected = '0;
        case (r_state)
            S_UP:    w_expected = (r_prev == MAX_L) ? MAX_L - ONE_L : w_prev_inc;
            S_DOWN:  w_expected = (r_prev == '0)    ? ONE_L         : w_prev_dec;
            default: w_expected = '0;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_mismatch  = 1'b0;
        w_turn      = 1'b0;
        if (sample_en) begin
            w_prev_nxt = count_in;
            case (r_state)
                S_IDLE: w_state_nxt = S_ACQ;
                S_ACQ: begin
                    if (r_prev < MAX_L && count_in == w_prev_inc) begin
                        w_state_nxt = S_UP;
                    end else if (r_prev != '0 && count_in == w_prev_dec) begin
                        w_state_nxt = S_DOWN;
                    end
                end
                S_UP: begin
                    if (count_in != w_expected) begin
                        w_mismatch  = 1'b1;
                        w_state_nxt = S_ACQ;
                    end else if (r_prev == MAX_L) begin
                        w_turn      = 1'b1;
                        w_state_nxt = S_DOWN;
                    end
                end
                S_DOWN: begin
                    if (count_in != w_expected) begin
                        w_mismatch  = 1'b1;
                        w_state_nxt = S_ACQ;
                    end else if (r_prev == '0) begin
                        w_turn      = 1'b1;
                        w_state_nxt = S_UP;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev     <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prev  <= w_prev_nxt;
            if (w_turn && r_turn_cnt != SAT_L) begin
                r_turn_cnt <= r_turn_cnt + CNT_W'(1);
            end
            // A mismatch on the same edge as clr_err survives the clear.
            if (w_mismatch) begin
                r_err <= 1'b1;
                if (clr_err) begin
                    r_err_cnt <= CNT_W'(1);
                end else if (r_err_cnt != SAT_L) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end else if (clr_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end
        end
    end

    assign locked   = (r_state == S_UP) || (r_state == S_DOWN);
    assign dir_up   = (r_state == S_UP);
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign turn_cnt = r_turn_cnt;
    assign expected = w_expected;

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Self-checking bench for updown_seq_monitor: directed scenarios plus a random
// triangle stream, all compared each cycle against a behavioural model.
module tb_updown_seq_monitor;

    localparam int WIDTH = 4;
    localparam int MAXV  = 15;
    localparam int CNT_W = 8;
    localparam int SAT   = 255;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sample_en = 1'b0;
    logic [WIDTH-1:0] count_in = '0;
    logic             clr_err = 1'b0;
    logic             locked;
    logic             dir_up;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] turn_cnt;
    logic [WIDTH-1:0] expected;

    updown_seq_monitor #(.WIDTH(WIDTH), .MAXV(MAXV), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .count_in  (count_in),
        .clr_err   (clr_err),
        .locked    (locked),
        .dir_up    (dir_up),
        .err       (err),
        .err_cnt   (err_cnt),
        .turn_cnt  (turn_cnt),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Behavioural model: "have we seen a sample", "are we locked", direction.
    bit m_seen, m_locked, m_up;
    int m_prev, m_err, m_errc, m_turn;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int m_pred();
        if (m_up) return (m_prev == MAXV) ? MAXV - 1 : m_prev + 1;
        return (m_prev == 0) ? 1 : m_prev - 1;
    endfunction

    task automatic model_update(input bit r, input bit en, input int c, input bit clr);
        bit mis;
        mis = 1'b0;
        if (r) begin
            m_seen = 0; m_locked = 0; m_up = 0;
            m_prev = 0; m_err = 0; m_errc = 0; m_turn = 0;
            return;
        end
        if (en) begin
            if (!m_seen) begin
                m_seen = 1;
            end else if (!m_locked) begin
                if (m_prev < MAXV && c == m_prev + 1) begin
                    m_locked = 1; m_up = 1;
                end else if (m_prev > 0 && c == m_prev - 1) begin
                    m_locked = 1; m_up = 0;
                end
            end else if (c == m_pred()) begin
                if ((m_up && m_prev == MAXV) || (!m_up && m_prev == 0)) begin
                    m_up = !m_up;
                    if (m_turn < SAT) m_turn++;
                end
            end else begin
                mis = 1; m_locked = 0;
            end
            m_prev = c;
        end
        if (clr) begin m_err = 0; m_errc = 0; end
        if (mis) begin
            m_err = 1;
            if (m_errc < SAT) m_errc++;
        end
    endtask

    // One clock cycle: drive at the falling edge, let the model see the same
    // inputs at the rising edge, then release the strobes.
    task automatic step(input bit r, input bit en, input int c, input bit clr);
        @(negedge clk);
        rst = r; sample_en = en; count_in = WIDTH'(c); clr_err = clr;
        @(posedge clk);
        model_update(r, en, c, clr);
        #1;
        rst = 0; sample_en = 0; clr_err = 0;
    endtask

    task automatic send(input int c);
        step(0, 1, c, 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",   int'(locked),   int'(m_locked));
            check("dir_up",   int'(dir_up),   int'(m_locked && m_up));
            check("err",      int'(err),      m_err);
            check("err_cnt",  int'(err_cnt),  m_errc);
            check("turn_cnt", int'(turn_cnt), m_turn);
            check("expected", int'(expected), m_locked ? m_pred() : 0);
        end
    end

    initial begin
        int g;
        bit gup;
        int v;

        // 1: reset with sample_en toggling
        step(1, 1, 5, 0);
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        check("rst_locked", int'(locked), 0);
        check("rst_dir", int'(dir_up), 0);
        check("rst_err", int'(err), 0);
        check("rst_errcnt", int'(err_cnt), 0);
        check("rst_turn", int'(turn_cnt), 0);
        check("rst_exp", int'(expected), 0);

        // 2: rising run to the top and the first step down
        send(0);
        check("tp2_acq_unlocked", int'(locked), 0);
        send(1);
        check("tp2_lock", int'(locked), 1);
        check("tp2_up", int'(dir_up), 1);
        check("tp2_exp2", int'(expected), 2);
        for (int i = 2; i <= 15; i++) send(i);
        check("tp2_exp_top", int'(expected), 14);
        send(14);
        check("tp2_down", int'(dir_up), 0);
        check("tp2_turn1", int'(turn_cnt), 1);
        check("tp2_noerr", int'(err), 0);
        check("tp2_exp13", int'(expected), 13);

        // 3: full triangle with random gaps
        step(1, 0, 0, 0);
        for (int i = 0; i <= 31; i++) begin
            v = (i <= 15) ? i : ((i <= 30) ? 30 - i : 1);
            send(v);
            for (int k = $urandom_range(0, 3); k > 0; k--) step(0, 0, $urandom_range(0, 15), 0);
        end
        check("tp3_turn2", int'(turn_cnt), 2);
        check("tp3_errcnt0", int'(err_cnt), 0);

        // 4: skipped value while counting up, then reacquire
        step(1, 0, 0, 0);
        send(3); send(4);
        send(6);
        check("tp4_err", int'(err), 1);
        check("tp4_errcnt", int'(err_cnt), 1);
        check("tp4_unlock", int'(locked), 0);
        send(7);
        check("tp4_relock", int'(locked), 1);
        check("tp4_reup", int'(dir_up), 1);
        send(8);
        check("tp4_errcnt_hold", int'(err_cnt), 1);

        // 5: repeated top value, reacquire downward, then a lone clear
        step(1, 0, 0, 0);
        send(13); send(14); send(15); send(15);
        check("tp5_errcnt", int'(err_cnt), 1);
        check("tp5_unlock", int'(locked), 0);
        send(14);
        check("tp5_down_lock", int'(locked), 1);
        check("tp5_down_dir", int'(dir_up), 0);
        check("tp5_no_new_err", int'(err_cnt), 1);
        step(0, 0, 0, 1);
        check("tp5_clr_err", int'(err), 0);
        check("tp5_clr_cnt", int'(err_cnt), 0);
        check("tp5_turn_kept", int'(turn_cnt), 0);
        check("tp5_lock_kept", int'(locked), 1);

        // 6: clear colliding with a mismatch, saturation, reset while DOWN
        step(0, 1, 10, 1);
        check("tp6_clr_vs_err", int'(err), 1);
        check("tp6_clr_vs_cnt", int'(err_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            send(2); send(3); send(9);
        end
        check("tp6_sat", int'(err_cnt), 255);
        send(5); send(4);
        check("tp6_in_down", int'(locked), 1);
        step(1, 0, 0, 0);
        check("tp6_rst_locked", int'(locked), 0);
        check("tp6_rst_dir", int'(dir_up), 0);
        check("tp6_rst_err", int'(err), 0);
        check("tp6_rst_errcnt", int'(err_cnt), 0);
        check("tp6_rst_turn", int'(turn_cnt), 0);
        check("tp6_rst_exp", int'(expected), 0);

        // Random triangle stream with corruptions, gaps, clears and resets
        g = 0; gup = 1;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                step(1, $urandom_range(0, 1), $urandom_range(0, 15), 0);
            end else if ($urandom_range(0, 3) == 0) begin
                step(0, 0, $urandom_range(0, 15), $urandom_range(0, 29) == 0);
            end else begin
                v = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : g;
                step(0, 1, v, $urandom_range(0, 29) == 0);
                if (gup) begin
                    if (v == MAXV) begin gup = 0; g = MAXV - 1; end else g = v + 1;
                end else begin
                    if (v == 0) begin gup = 1; g = 1; end else g = v - 1;
                end
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
